core_sequencer: RTL and testbench

CORE_SEQUENCER -- requirements
Module: core_sequencer

---
 rtl/core_sequencer.sv | 178 +++++++++++++++++
 tb/tb_core_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: walks FETCH/DECODE/EXEC/MEM/WB with per-stage
// start pulses, a stage timeout watchdog, halt handling and a retired-instruction counter.
module core_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [15:0] TIMEOUT  = 16'd1023
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start_i,
    input  logic        halt_req_i,
    input  logic        fetch_done_i,
    input  logic        decode_done_i,
    input  logic        exec_done_i,
    input  logic        mem_done_i,
    input  logic [5:0]  exec_command_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    output logic        fetch_enable_o,
    output logic        decode_enable_o,
    output logic        exec_enable_o,
    output logic        mem_enable_o,
    output logic        wb_enable_o,
    output logic [31:0] pc_o,
    output logic        running_o,
    output logic        fault_o,
    output logic [2:0]  fault_state_o,
    output logic [31:0] retired_o
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StHalted = 3'd6,
        StFault  = 3'd7
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] retired_q, retired_d;
    logic        fault_q, fault_d;
    logic [2:0]  fault_state_q, fault_state_d;
    logic [5:0]  cmd_q, cmd_d;
    logic        br_taken_q, br_taken_d;
    logic [31:0] br_target_q, br_target_d;
    logic        halt_q, halt_d;

    logic stage_done;
    logic waiting;
    logic needs_mem;
    logic writes_rf;

    assign needs_mem = (cmd_q[5:4] == 2'b10) || (cmd_q == 6'b110001) || (cmd_q == 6'b111001);
    assign writes_rf = !((cmd_q[5:3] == 3'b101) || (cmd_q == 6'b111001) ||
                         (cmd_q == 6'b000010) || (cmd_q == 6'b000100) || (cmd_q == 6'b000101));

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pc_d          = pc_q;
        retired_d     = retired_q;
        fault_d       = fault_q;
        fault_state_d = fault_state_q;
        cmd_d         = cmd_q;
        br_taken_d    = br_taken_q;
        br_target_d   = br_target_q;
        halt_d        = halt_q | halt_req_i;
        stage_done    = 1'b0;
        waiting       = 1'b0;

        case (state_q)
            StIdle, StHalted, StFault: begin
                if (start_i) begin
                    pc_d      = RESET_PC;
                    retired_d = 32'd0;
                    fault_d   = 1'b0;
                    state_d   = StFetch;
                end
            end
            StFetch: begin
                waiting    = 1'b1;
                stage_done = fetch_done_i;
                if (fetch_done_i) state_d = StDecode;
            end
            StDecode: begin
                waiting    = 1'b1;
                stage_done = decode_done_i;
                if (decode_done_i) begin
                    cmd_d   = exec_command_i;
                    state_d = StExec;
                end
            end
            StExec: begin
                waiting    = 1'b1;
                stage_done = exec_done_i;
                if (exec_done_i) begin
                    br_taken_d  = branch_taken_i;
                    br_target_d = branch_target_i;
                    state_d     = needs_mem ? StMem : StWb;
                end
            end
            StMem: begin
                waiting    = 1'b1;
                stage_done = mem_done_i;
                if (mem_done_i) state_d = StWb;
            end
            StWb: begin
                retired_d = retired_q + 32'd1;
                pc_d      = br_taken_q ? br_target_q : pc_q + 32'd4;
                state_d   = (halt_q || halt_req_i) ? StHalted : StFetch;
            end
            default: state_d = StIdle;
        endcase

        // Watchdog: the cycle with cnt_q == TIMEOUT is the last one a stage may finish in.
        if (waiting && !stage_done) begin
            if (cnt_q == TIMEOUT) begin
                state_d       = StFault;
                fault_d       = 1'b1;
                fault_state_d = state_q;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end

        if (state_d != state_q) begin
            cnt_d = 16'd0;
            if (state_d == StFetch) begin
                halt_d     = 1'b0;
                br_taken_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= StIdle;
            cnt_q         <= 16'd0;
            pc_q          <= RESET_PC;
            retired_q     <= 32'd0;
            fault_q       <= 1'b0;
            fault_state_q <= 3'd0;
            cmd_q         <= 6'd0;
            br_taken_q    <= 1'b0;
            br_target_q   <= 32'd0;
            halt_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pc_q          <= pc_d;
            retired_q     <= retired_d;
            fault_q       <= fault_d;
            fault_state_q <= fault_state_d;
            cmd_q         <= cmd_d;
            br_taken_q    <= br_taken_d;
            br_target_q   <= br_target_d;
            halt_q        <= halt_d;
        end
    end

    // The wait counter is zero only in the first cycle of a state.
    assign fetch_enable_o  = (state_q == StFetch)  && (cnt_q == 16'd0);
    assign decode_enable_o = (state_q == StDecode) && (cnt_q == 16'd0);
    assign exec_enable_o   = (state_q == StExec)   && (cnt_q == 16'd0);
    assign mem_enable_o    = (state_q == StMem)    && (cnt_q == 16'd0);
    assign wb_enable_o     = (state_q == StWb) && writes_rf;

    assign running_o     = !((state_q == StIdle) || (state_q == StHalted) || (state_q == StFault));
    assign pc_o          = pc_q;
    assign retired_o     = retired_q;
    assign fault_o       = fault_q;
    assign fault_state_o = fault_state_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: instruction mixes, branch, halt, timeout fault and
// mid-instruction reset, each checked against hand-computed pc/retired/strobe counts.
module tb_core_sequencer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start_i, halt_req_i;
    logic        fetch_done_i, decode_done_i, exec_done_i, mem_done_i;
    logic [5:0]  exec_command_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic        fetch_enable_o, decode_enable_o, exec_enable_o, mem_enable_o, wb_enable_o;
    logic [31:0] pc_o, retired_o;
    logic        running_o, fault_o;
    logic [2:0]  fault_state_o;

    int total = 0;
    int bad   = 0;
    int n_f = 0, n_d = 0, n_e = 0, n_m = 0, n_w = 0;

    logic [3:0] ens;
    assign ens = {mem_enable_o, exec_enable_o, decode_enable_o, fetch_enable_o};

    core_sequencer #(
        .RESET_PC (32'h0000_0000),
        .TIMEOUT  (16'd8)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .start_i         (start_i),
        .halt_req_i      (halt_req_i),
        .fetch_done_i    (fetch_done_i),
        .decode_done_i   (decode_done_i),
        .exec_done_i     (exec_done_i),
        .mem_done_i      (mem_done_i),
        .exec_command_i  (exec_command_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .fetch_enable_o  (fetch_enable_o),
        .decode_enable_o (decode_enable_o),
        .exec_enable_o   (exec_enable_o),
        .mem_enable_o    (mem_enable_o),
        .wb_enable_o     (wb_enable_o),
        .pc_o            (pc_o),
        .running_o       (running_o),
        .fault_o         (fault_o),
        .fault_state_o   (fault_state_o),
        .retired_o       (retired_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fetch_enable_o)  n_f++;
        if (decode_enable_o) n_d++;
        if (exec_enable_o)   n_e++;
        if (mem_enable_o)    n_m++;
        if (wb_enable_o)     n_w++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_en(input int idx, input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (ens[idx]) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check_eq({tag, "_en"}, {31'd0, found}, 32'd1);
    endtask

    task automatic pulse_done(input int idx);
        case (idx)
            0: fetch_done_i  = 1'b1;
            1: decode_done_i = 1'b1;
            2: exec_done_i   = 1'b1;
            default: mem_done_i = 1'b1;
        endcase
        step();
        fetch_done_i  = 1'b0;
        decode_done_i = 1'b0;
        exec_done_i   = 1'b0;
        mem_done_i    = 1'b0;
    endtask

    // Runs one instruction from its FETCH cycle through to the cycle after WB.
    task automatic run_instr(input string tag, input logic [5:0] op, input logic bt,
                             input logic [31:0] tgt, input logic hlt, input int exp_mem,
                             input int exp_wb, input logic [31:0] exp_pc,
                             input logic [31:0] exp_ret);
        int f0 = n_f, d0 = n_d, e0 = n_e, m0 = n_m, w0 = n_w;
        exec_command_i = op;
        wait_en(0, {tag, "_f"});
        pulse_done(0);
        wait_en(1, {tag, "_d"});
        pulse_done(1);
        wait_en(2, {tag, "_e"});
        branch_taken_i  = bt;
        branch_target_i = tgt;
        halt_req_i      = hlt;
        pulse_done(2);
        branch_taken_i  = 1'b0;
        branch_target_i = 32'hDEAD_BEEF;
        halt_req_i      = 1'b0;
        if (exp_mem != 0) begin
            wait_en(3, {tag, "_m"});
            pulse_done(3);
        end
        step();
        check_eq({tag, "_nf"}, n_f - f0, 1);
        check_eq({tag, "_nd"}, n_d - d0, 1);
        check_eq({tag, "_ne"}, n_e - e0, 1);
        check_eq({tag, "_nm"}, n_m - m0, exp_mem);
        check_eq({tag, "_nw"}, n_w - w0, exp_wb);
        check_eq({tag, "_pc"}, pc_o, exp_pc);
        check_eq({tag, "_ret"}, retired_o, exp_ret);
    endtask

    initial begin
        int f0, d0;
        rstn = 1'b0; start_i = 1'b0; halt_req_i = 1'b0;
        fetch_done_i = 1'b1; decode_done_i = 1'b0; exec_done_i = 1'b1; mem_done_i = 1'b0;
        exec_command_i = 6'd0; branch_taken_i = 1'b0; branch_target_i = 32'd0;

        // Reset with stray done pulses.
        repeat (3) step();
        check_eq("rst_pc", pc_o, 32'h0);
        check_eq("rst_ret", retired_o, 32'h0);
        check_eq("rst_run", {31'd0, running_o}, 32'd0);
        check_eq("rst_flt", {29'd0, fault_state_o, fault_o}, 32'd0);
        check_eq("rst_ens", {27'd0, wb_enable_o, ens}, 32'd0);
        rstn = 1'b1;
        step();
        exec_done_i  = 1'b0;
        fetch_done_i = 1'b0;
        check_eq("post_rst_idle", {31'd0, running_o}, 32'd0);

        start_i = 1'b1;
        step();
        start_i = 1'b0;
        check_eq("start_run", {31'd0, running_o}, 32'd1);

        run_instr("alu", 6'b000000, 1'b0, 32'h0, 1'b0, 0, 1, 32'h04, 32'd1);
        start_i = 1'b1;  // must be ignored while running
        run_instr("load", 6'b100011, 1'b0, 32'h0, 1'b0, 1, 1, 32'h08, 32'd2);
        start_i = 1'b0;
        run_instr("store", 6'b101011, 1'b0, 32'h0, 1'b0, 1, 0, 32'h0C, 32'd3);
        run_instr("br_t", 6'b000100, 1'b1, 32'h40, 1'b0, 0, 0, 32'h40, 32'd4);
        run_instr("br_nt", 6'b000100, 1'b0, 32'h80, 1'b0, 0, 0, 32'h44, 32'd5);
        run_instr("op39", 6'b111001, 1'b0, 32'h0, 1'b0, 1, 0, 32'h48, 32'd6);
        run_instr("op31", 6'b110001, 1'b0, 32'h0, 1'b0, 1, 1, 32'h4C, 32'd7);
        run_instr("halt", 6'b000000, 1'b0, 32'h0, 1'b1, 0, 1, 32'h50, 32'd8);
        check_eq("halt_run", {31'd0, running_o}, 32'd0);
        f0 = n_f;
        repeat (10) step();
        check_eq("halt_nofetch", n_f - f0, 0);
        check_eq("halt_pc", pc_o, 32'h50);

        start_i = 1'b1;
        step();
        start_i = 1'b0;
        check_eq("restart_pc", pc_o, 32'h0);
        check_eq("restart_ret", retired_o, 32'h0);
        run_instr("alu2", 6'b000000, 1'b0, 32'h0, 1'b0, 0, 1, 32'h04, 32'd1);

        // Timeout in DECODE; other stages' done pulses must not rescue it.
        d0 = n_d;
        wait_en(0, "to_f");
        pulse_done(0);
        wait_en(1, "to_d");
        fetch_done_i = 1'b1; exec_done_i = 1'b1; mem_done_i = 1'b1;
        repeat (8) step();
        fetch_done_i = 1'b0; exec_done_i = 1'b0; mem_done_i = 1'b0;
        check_eq("to_pre_fault", {31'd0, fault_o}, 32'd0);
        step();
        check_eq("to_fault", {31'd0, fault_o}, 32'd1);
        check_eq("to_fstate", {29'd0, fault_state_o}, 32'd2);
        check_eq("to_run", {31'd0, running_o}, 32'd0);
        check_eq("to_pc_hold", pc_o, 32'h04);
        check_eq("to_ret_hold", retired_o, 32'd1);
        check_eq("to_nd", n_d - d0, 1);
        repeat (3) step();
        check_eq("to_ens", {27'd0, wb_enable_o, ens}, 32'd0);

        start_i = 1'b1;
        step();
        start_i = 1'b0;
        check_eq("fstart_flt", {31'd0, fault_o}, 32'd0);
        check_eq("fstart_pc", pc_o, 32'h0);
        check_eq("fstart_fen", {31'd0, fetch_enable_o}, 32'd1);
        run_instr("alu3", 6'b000000, 1'b0, 32'h0, 1'b0, 0, 1, 32'h04, 32'd1);

        // Reset in the middle of a load's MEM stage.
        exec_command_i = 6'b100011;
        wait_en(0, "mr_f");
        pulse_done(0);
        wait_en(1, "mr_d");
        pulse_done(1);
        wait_en(2, "mr_e");
        pulse_done(2);
        wait_en(3, "mr_m");
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        check_eq("mr_run", {31'd0, running_o}, 32'd0);
        check_eq("mr_pc", pc_o, 32'h0);
        check_eq("mr_ret", retired_o, 32'd0);
        check_eq("mr_flt", {29'd0, fault_state_o, fault_o}, 32'd0);
        check_eq("mr_ens", {27'd0, wb_enable_o, ens}, 32'd0);
        mem_done_i = 1'b1;
        step();
        mem_done_i = 1'b0;
        step();
        check_eq("mr_idle", {27'd0, wb_enable_o, ens} | {31'd0, running_o}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
